// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: receiver state encoding plus baud-divider and counter-width helpers
package uart_rx_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HI} rx_state_t;

    // Clock cycles per oversampling tick, truncated.
    function automatic int baud_div(input int clk_hz, input int baud, input int os);
        return clk_hz / (baud * os);
    endfunction

    // Width of a counter that must reach n-1.
    function automatic int cnt_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: single-clock oversampling tick enable, phase-lockable by clr/en
// Ports: clk, areset_n (async, active-low), clr (restart phase), en (run counter),
//        tick (one-cycle pulse every DIV cycles while en).
module uart_baud_tick
    import uart_rx_pkg::*;
#(
    parameter int DIV = baud_div(100_000_000, 9600, 16)
) (
    input  logic clk,
    input  logic areset_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int W = cnt_w(DIV);
    localparam logic [W-1:0] TOP = W'(DIV - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n)
            cnt <= '0;
        else
            cnt <= (clr || !en || cnt == TOP) ? '0 : cnt + 1'b1;
    end

    assign tick = en && cnt == TOP;

endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: oversampling UART receiver with mid-bit sampling and valid/ready output
// Ports: clk, areset_n (async, active-low), rx (async line, idle high),
//        rx_data/rx_valid/rx_ready (byte handshake), busy (not IDLE),
//        frame_err, overrun, par_err (one-cycle pulses).
// Optional: UART_RX_PARITY_EN adds an even-parity bit, the PARITY state and par_err.
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 areset_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 busy,
    output logic                 frame_err,
`ifdef UART_RX_PARITY_EN
    output logic                 par_err,
`endif
    output logic                 overrun
);

    localparam int DIV = baud_div(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int SW  = cnt_w(OVERSAMPLE);
    localparam int BW  = cnt_w(DATA_BITS);
    localparam logic [SW-1:0] MID   = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] LAST  = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BLAST = BW'(DATA_BITS - 1);

    rx_state_t            state;
    logic                 rx_m, rx_s, tick, bit_end, deliver;
    logic [SW-1:0]        scnt;
    logic [BW-1:0]        bcnt;
    logic [DATA_BITS-1:0] shreg;
`ifdef UART_RX_PARITY_EN
    logic                 par_bad;
`endif

    // Reset to the idle level so a reset never looks like a start edge.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n)
            {rx_m, rx_s} <= 2'b11;
        else
            {rx_m, rx_s} <= {rx, rx_m};
    end

    // Tick phase is frozen while waiting for an edge, so the first tick lands
    // DIV cycles after the start edge is seen.
    uart_baud_tick #(.DIV(DIV)) u_tick (
        .clk      (clk),
        .areset_n (areset_n),
        .clr      (state == IDLE && !rx_s),
        .en       (state != IDLE && state != WAIT_HI),
        .tick     (tick)
    );

    assign busy = state != IDLE;

    always_comb begin
        bit_end = tick && scnt == LAST;
`ifdef UART_RX_PARITY_EN
        deliver = state == STOP && bit_end && rx_s && !par_bad;
`else
        deliver = state == STOP && bit_end && rx_s;
`endif
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state     <= IDLE;
            scnt      <= '0;
            bcnt      <= '0;
            shreg     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err   <= 1'b0;
            par_bad   <= 1'b0;
`endif
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err   <= 1'b0;
`endif
            if (rx_valid && rx_ready)
                rx_valid <= 1'b0;
            // A delivery overrides the handshake clear above.
            if (deliver) begin
                if (!rx_valid || rx_ready) begin
                    rx_data  <= shreg;
                    rx_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end
            case (state)
                IDLE: if (!rx_s) begin
                    state <= START;
                    scnt  <= '0;
                    bcnt  <= '0;
                end
                START: if (tick) begin
                    scnt <= (scnt == MID) ? '0 : scnt + 1'b1;
                    if (scnt == MID)
                        state <= rx_s ? IDLE : DATA;
                end
                DATA: if (tick) begin
                    scnt <= bit_end ? '0 : scnt + 1'b1;
                    if (bit_end) begin
                        shreg <= {rx_s, shreg[DATA_BITS-1:1]};
                        bcnt  <= bcnt + 1'b1;
`ifdef UART_RX_PARITY_EN
                        if (bcnt == BLAST)
                            state <= PARITY;
`else
                        if (bcnt == BLAST)
                            state <= STOP;
`endif
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: if (tick) begin
                    scnt <= bit_end ? '0 : scnt + 1'b1;
                    if (bit_end) begin
                        par_bad <= ^{shreg, rx_s};
                        state   <= STOP;
                    end
                end
`endif
                STOP: if (tick) begin
                    scnt <= bit_end ? '0 : scnt + 1'b1;
                    if (bit_end) begin
                        state     <= rx_s ? IDLE : WAIT_HI;
                        frame_err <= !rx_s;
`ifdef UART_RX_PARITY_EN
                        par_err   <= rx_s && par_bad;
`endif
                    end
                end
                // Hold off until the line returns high so a break is one error.
                WAIT_HI: if (rx_s)
                    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: timeline-model checked bench for uart_rx_ctrl at 4 clocks per tick
module tb_uart_rx_ctrl;

    localparam int DIV  = 4;
    localparam int OS   = 16;
    localparam int DB   = 8;
    localparam int BIT  = DIV * OS;
    localparam int HALF = BIT / 2;
`ifdef UART_RX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    // Edge on which the byte is delivered, counted from the edge after which rx falls.
    localparam int LAT = 3 + HALF + (DB + PB + 1) * BIT;

    logic       clk = 1'b0;
    logic       areset_n = 1'b0;
    logic       rx = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, busy, frame_err, overrun, dut_pe;
`ifdef UART_RX_PARITY_EN
    logic       par_err;
    assign dut_pe = par_err;
`else
    assign dut_pe = 1'b0;
`endif

    uart_rx_ctrl #(
        .CLK_HZ(64_000_000), .BAUD(1_000_000), .OVERSAMPLE(OS), .DATA_BITS(DB)
    ) dut (
        .clk       (clk),
        .areset_n  (areset_n),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .busy      (busy),
        .frame_err (frame_err),
`ifdef UART_RX_PARITY_EN
        .par_err   (par_err),
`endif
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int ntest = 0, nfail = 0;

    // Reference model: the line as the receiver sees it (two edges late), with
    // each sample placed at start-edge + half bit + k whole bits.
    int         ms = 0;
    int         t0 = 0, k = 0;
    logic       h1 = 1'b1, h2 = 1'b1, seen, vb, pbad = 1'b0;
    logic [7:0] acc = '0;
    logic       e_valid = 1'b0, e_fe = 1'b0, e_ov = 1'b0, e_pe = 1'b0;
    logic [7:0] e_data = '0;

    always @(posedge clk or negedge areset_n) begin
        int n;
        if (!areset_n) begin
            ms = 0; h1 = 1'b1; h2 = 1'b1; pbad = 1'b0;
            e_valid = 1'b0; e_data = '0; e_fe = 1'b0; e_ov = 1'b0; e_pe = 1'b0;
        end else begin
            n = cyc + 1;
            seen = h2; h2 = h1; h1 = rx;
            vb = e_valid;
            e_fe = 1'b0; e_ov = 1'b0; e_pe = 1'b0;
            if (e_valid && rx_ready) e_valid = 1'b0;
            if (ms == 0) begin
                if (!seen) begin ms = 1; t0 = n; k = 0; acc = '0; end
            end else if (ms == 2) begin
                if (seen) ms = 0;
            end else if (n == t0 + HALF + k * BIT) begin
                if (k == 0) begin
                    if (seen) ms = 0;
                end else if (k <= DB) begin
                    acc[k-1] = seen;
                end else if (PB == 1 && k == DB + 1) begin
                    pbad = (^acc) ^ seen;
                end else if (!seen) begin
                    e_fe = 1'b1; ms = 2;
                end else begin
                    ms = 0;
                    if (PB == 1 && pbad) e_pe = 1'b1;
                    else if (!vb || rx_ready) begin e_data = acc; e_valid = 1'b1; end
                    else e_ov = 1'b1;
                end
                k++;
            end
        end
    end

    int         n_fe = 0, n_ov = 0, n_pe = 0, n_vc = 0, last_rise = -1;
    logic [7:0] last_rdata = '0;
    logic       pv = 1'b0;

    always @(negedge clk) begin
        ntest++;
        if ({rx_valid, rx_data, busy, frame_err, overrun, dut_pe} !==
            {e_valid, e_data, ms != 0, e_fe, e_ov, e_pe}) begin
            nfail++;
            $display("FAIL cycle %0d outputs: got v=%b d=%h busy=%b fe=%b ov=%b pe=%b, expected v=%b d=%h busy=%b fe=%b ov=%b pe=%b",
                     cyc, rx_valid, rx_data, busy, frame_err, overrun, dut_pe,
                     e_valid, e_data, ms != 0, e_fe, e_ov, e_pe);
        end
        if (frame_err) n_fe++;
        if (overrun) n_ov++;
        if (dut_pe) n_pe++;
        if (rx_valid) n_vc++;
        if (rx_valid && !pv) begin last_rise = cyc; last_rdata = rx_data; end
        pv = rx_valid;
    end

    logic rnd_ready = 1'b0;
    int   pulse_at = -10;
    int   frame_start = 0;

    initial forever begin
        @(posedge clk); #1;
        if (rnd_ready) rx_ready = 1'($urandom_range(0, 1));
        else if (cyc == pulse_at) rx_ready = 1'b1;
        else if (cyc == pulse_at + 1) rx_ready = 1'b0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntest++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Leaves rx at the stop level; the caller returns the line high.
    task automatic send(input logic [7:0] d, input logic stop, input logic par);
        @(posedge clk); #1;
        frame_start = cyc;
        rx = 1'b0; hold(BIT);
        for (int i = 0; i < DB; i++) begin rx = d[i]; hold(BIT); end
        if (PB == 1) begin rx = par; hold(BIT); end
        rx = stop; hold(BIT);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int b_fe, b_ov, b_pe, b_vc;
        logic [7:0] d;
        logic st, pa;
        repeat (3) @(posedge clk); #1;
        chk("rst_valid", rx_valid, 0);
        chk("rst_data", rx_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pulses", {frame_err, overrun, dut_pe}, 0);
        areset_n = 1'b1;
        rx_ready = 1'b1;
        hold(5);

        b_fe = n_fe; b_ov = n_ov; b_vc = n_vc;
        send(8'hA5, 1'b1, ^8'hA5); rx = 1'b1; hold(20);
        chk("a5_latency", last_rise - frame_start, PB == 1 ? 675 : 611);
        chk("a5_data", last_rdata, 8'hA5);
        chk("a5_model", e_data, 8'hA5);
        chk("a5_valid_cycles", n_vc - b_vc, 1);
        chk("a5_no_errors", (n_fe - b_fe) + (n_ov - b_ov), 0);

        b_fe = n_fe; b_ov = n_ov; b_vc = n_vc;
        rx = 1'b0; hold(10);
        chk("glitch_busy_high", busy, 1);
        hold(10); rx = 1'b1; hold(BIT);
        chk("glitch_busy_low", busy, 0);
        chk("glitch_no_valid", n_vc - b_vc, 0);
        chk("glitch_no_pulse", (n_fe - b_fe) + (n_ov - b_ov), 0);

        b_fe = n_fe; b_vc = n_vc;
        send(8'h3C, 1'b0, ^8'h3C); hold(300);
        chk("break_busy_held", busy, 1);
        chk("break_frame_err", n_fe - b_fe, 1);
        rx = 1'b1; hold(10);
        chk("break_busy_low", busy, 0);
        chk("break_no_valid", n_vc - b_vc, 0);

        rx_ready = 1'b0;
        b_ov = n_ov;
        send(8'h11, 1'b1, ^8'h11); rx = 1'b1;
        send(8'h22, 1'b1, ^8'h22); rx = 1'b1; hold(20);
        chk("ovr_data_kept", rx_data, 8'h11);
        chk("ovr_valid", rx_valid, 1);
        chk("ovr_pulse", n_ov - b_ov, 1);
        rx_ready = 1'b1; hold(1); rx_ready = 1'b0;
        chk("ovr_consumed", rx_valid, 0);

        b_ov = n_ov;
        send(8'h11, 1'b1, ^8'h11); rx = 1'b1;
        fork
            send(8'h22, 1'b1, ^8'h22);
            begin @(posedge clk); #2; pulse_at = frame_start + LAT - 1; end
        join
        rx = 1'b1; hold(20);
        chk("same_cycle_data", rx_data, 8'h22);
        chk("same_cycle_valid", rx_valid, 1);
        chk("same_cycle_no_ovr", n_ov - b_ov, 0);

        @(posedge clk); #1;
        rx = 1'b0; hold(BIT);
        for (int i = 0; i < 4; i++) begin rx = 1'b1; hold(BIT); end
        rx = 1'b0; hold(HALF);
        chk("mid_frame_busy", busy, 1);
        areset_n = 1'b0; #1;
        chk("async_rst_valid", rx_valid, 0);
        chk("async_rst_data", rx_data, 0);
        chk("async_rst_busy", busy, 0);
        hold(10);
        areset_n = 1'b1; rx = 1'b1; hold(2 * BIT);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_valid", rx_valid, 0);
        send(8'h5A, 1'b1, ^8'h5A); rx = 1'b1; hold(BIT);
        chk("post_rst_data", rx_data, 8'h5A);
        chk("post_rst_rx_valid", rx_valid, 1);
        chk("post_rst_model", e_data, 8'h5A);

        rnd_ready = 1'b1;
        for (int f = 0; f < 40; f++) begin
            d  = 8'($urandom);
            st = $urandom_range(0, 9) != 0;
            pa = (^d) ^ ($urandom_range(0, 7) == 0);
            send(d, st, pa);
            if (!st) hold($urandom_range(1, 100));
            rx = 1'b1;
            hold($urandom_range(1, BIT));
        end
        rnd_ready = 1'b0;
        rx_ready = 1'b1;
        hold(20);
        chk("drain_valid", rx_valid, 0);

        if (PB == 1) begin
            b_pe = n_pe; b_vc = n_vc;
            send(8'h07, 1'b1, 1'b0); rx = 1'b1; hold(20);
            chk("par_bad_pulse", n_pe - b_pe, 1);
            chk("par_bad_no_valid", n_vc - b_vc, 0);
            b_pe = n_pe; b_vc = n_vc;
            send(8'h07, 1'b1, 1'b1); rx = 1'b1; hold(20);
            chk("par_ok_data", last_rdata, 8'h07);
            chk("par_ok_valid", n_vc - b_vc, 1);
            chk("par_ok_no_pulse", n_pe - b_pe, 0);
        end

        $display("[TB] %0d tests run, %0d failed", ntest, nfail);
        $finish;
    end

endmodule
